// File: rtl/out_bits_packer_if.sv
// Stream bundle between the encoder's out_bits stage, the packer and the output FIFO/DMA.
// total_bits exists only when PACKER_STATS_EN is defined.
interface out_bits_packer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_WIDTH = 5
);
  logic                         in_valid;
  logic                         in_ready;
  logic [IN_WIDTH-1:0]          in_bits;
  logic [CNT_WIDTH-1:0]         in_count;
  logic                         flush_req;
  logic                         out_valid;
  logic                         out_ready;
  logic [OUT_WIDTH-1:0]         out_word;
  logic [$clog2(OUT_WIDTH):0]   out_bits_valid;
  logic                         out_last;
  logic                         flush_done;
`ifdef PACKER_STATS_EN
  logic [31:0]                  total_bits;
`endif

  // master: upstream encoder plus downstream sink; slave: the packer itself
  modport master (
    output in_valid, in_bits, in_count, flush_req, out_ready,
    input  in_ready, out_valid, out_word, out_bits_valid, out_last, flush_done
`ifdef PACKER_STATS_EN
    , input total_bits
`endif
  );

  modport slave (
    input  in_valid, in_bits, in_count, flush_req, out_ready,
    output in_ready, out_valid, out_word, out_bits_valid, out_last, flush_done
`ifdef PACKER_STATS_EN
    , output total_bits
`endif
  );
endinterface

// File: rtl/out_bits_packer.sv
// Packs variable-length MSB-aligned bit groups into fixed-width words; flush closes the stream.
// Optional PACKER_STATS_EN adds a saturating total_bits counter.
module out_bits_packer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  out_bits_packer_if.slave bus
);
  localparam int BW  = OUT_WIDTH + IN_WIDTH;
  localparam int FW  = $clog2(BW + 1);
  localparam int OBW = $clog2(OUT_WIDTH) + 1;

  typedef enum logic [1:0] {RUN, DRAIN, LAST} state_e;

  state_e              state_q;
  logic [BW-1:0]       buf_q, buf_d, buf_s;
  logic [FW-1:0]       fill_q, fill_d, fill_s;
  logic                flush_done_q;
  logic                acc, emit;
  logic [FW-1:0]       cnt;
  logic [IN_WIDTH-1:0] grp;

  assign bus.in_ready       = (state_q == RUN) && (fill_q <= FW'(OUT_WIDTH));
  assign bus.out_valid      = (state_q == LAST) || (fill_q >= FW'(OUT_WIDTH));
  assign bus.out_last       = (state_q == LAST);
  assign bus.out_word       = buf_q[BW-1 -: OUT_WIDTH];
  assign bus.out_bits_valid = !bus.out_valid   ? '0 :
                              (state_q == LAST) ? OBW'(fill_q) : OBW'(OUT_WIDTH);
  assign bus.flush_done     = flush_done_q;

  assign acc  = bus.in_valid && bus.in_ready;
  assign emit = bus.out_valid && bus.out_ready;
  assign cnt  = (bus.in_count > CNT_WIDTH'(IN_WIDTH)) ? FW'(IN_WIDTH) : FW'(bus.in_count);
  assign grp  = bus.in_bits & ~({IN_WIDTH{1'b1}} >> cnt);

  // Shift out the emitted word first so a same-cycle insert lands at fill-OUT_WIDTH.
  always_comb begin
    buf_s  = buf_q;
    fill_s = fill_q;
    if (emit) begin
      if (state_q == LAST) begin
        buf_s  = '0;
        fill_s = '0;
      end else begin
        buf_s  = buf_q << OUT_WIDTH;
        fill_s = fill_q - FW'(OUT_WIDTH);
      end
    end
    buf_d  = buf_s;
    fill_d = fill_s;
    if (acc) begin
      buf_d  = buf_s | ({grp, {OUT_WIDTH{1'b0}}} >> fill_s);
      fill_d = fill_s + cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      buf_q        <= '0;
      fill_q       <= '0;
      flush_done_q <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      flush_done_q <= 1'b0;
      case (state_q)
        RUN:   if (bus.flush_req) state_q <= DRAIN;
        DRAIN: if (fill_q < FW'(OUT_WIDTH)) state_q <= LAST;
        LAST:  if (emit) begin
                 state_q      <= RUN;
                 flush_done_q <= 1'b1;
               end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef PACKER_STATS_EN
  logic [31:0] total_q, total_d;
  logic [31:0] total_base;
  logic [32:0] total_sum;

  always_comb begin
    total_base = flush_done_q ? 32'd0 : total_q;
    total_sum  = {1'b0, total_base} + (acc ? 33'(cnt) : 33'd0);
    total_d    = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) total_q <= '0;
    else     total_q <= total_d;
  end

  assign bus.total_bits = total_q;
`endif
endmodule

// File: tb/tb_out_bits_packer.sv
// Directed bench for out_bits_packer: full groups, flush, backpressure, odd counts, reset.
module tb_out_bits_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  out_bits_packer_if #(.IN_WIDTH(16), .OUT_WIDTH(32), .CNT_WIDTH(5)) bi ();

  out_bits_packer #(.IN_WIDTH(16), .OUT_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bi.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] b, input logic [4:0] c, input logic f);
    bi.in_valid  = v;
    bi.in_bits   = b;
    bi.in_count  = c;
    bi.flush_req = f;
  endtask

  task automatic test_reset();
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    bi.out_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    total++; if (bi.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", bi.out_valid); end
    total++; if (bi.out_word !== 32'h0) begin bad++; $display("FAIL rst_out_word got=%h exp=0", bi.out_word); end
    total++; if (bi.out_last !== 1'b0 || bi.flush_done !== 1'b0 || bi.out_bits_valid !== 6'd0) begin
      bad++; $display("FAIL rst_flags got last=%0b done=%0b bv=%0d exp 0/0/0", bi.out_last, bi.flush_done, bi.out_bits_valid); end
    rst = 1'b0;
    #1;
    total++; if (bi.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", bi.in_ready); end
  endtask

  task automatic test_full_groups();
    bi.out_ready = 1'b1;
    drive(1'b1, 16'hABCD, 5'd16, 1'b0); tick();
    tick();
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    total++; if (bi.out_valid !== 1'b1 || bi.out_word !== 32'hABCDABCD) begin
      bad++; $display("FAIL full_word got v=%0b w=%h exp v=1 w=abcdabcd", bi.out_valid, bi.out_word); end
    total++; if (bi.out_last !== 1'b0 || bi.out_bits_valid !== 6'd32) begin
      bad++; $display("FAIL full_flags got last=%0b bv=%0d exp 0/32", bi.out_last, bi.out_bits_valid); end
    tick();
    total++; if (bi.out_valid !== 1'b0 || bi.in_ready !== 1'b1) begin
      bad++; $display("FAIL full_drained got v=%0b rdy=%0b exp 0/1", bi.out_valid, bi.in_ready); end
  endtask

  task automatic test_short_flush();
    bi.out_ready = 1'b0;
    drive(1'b1, 16'hB000, 5'd5, 1'b0); tick();
    drive(1'b1, 16'h6000, 5'd3, 1'b0); tick();
    drive(1'b0, 16'h0, 5'd0, 1'b1); tick();
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    for (int k = 0; k < 8 && !bi.out_valid; k++) tick();
    total++; if (bi.out_valid !== 1'b1 || bi.out_word !== 32'hB3000000) begin
      bad++; $display("FAIL short_word got v=%0b w=%h exp v=1 w=b3000000", bi.out_valid, bi.out_word); end
    total++; if (bi.out_last !== 1'b1 || bi.out_bits_valid !== 6'd8) begin
      bad++; $display("FAIL short_flags got last=%0b bv=%0d exp 1/8", bi.out_last, bi.out_bits_valid); end
    total++; if (bi.in_ready !== 1'b0) begin bad++; $display("FAIL short_in_ready got=%0b exp=0", bi.in_ready); end
    bi.out_ready = 1'b1;
    tick();
    total++; if (bi.flush_done !== 1'b1 || bi.out_valid !== 1'b0) begin
      bad++; $display("FAIL short_done got done=%0b v=%0b exp 1/0", bi.flush_done, bi.out_valid); end
    tick();
    total++; if (bi.flush_done !== 1'b0) begin bad++; $display("FAIL short_done_pulse got=%0b exp=0", bi.flush_done); end
  endtask

  task automatic test_backpressure();
    bi.out_ready = 1'b0;
    drive(1'b1, 16'hFFFF, 5'd16, 1'b0);
    tick(); tick(); tick();
    total++; if (bi.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b exp=0", bi.in_ready); end
    // Offered zeros must not be accepted while stalled.
    drive(1'b1, 16'h0000, 5'd16, 1'b0);
    tick(); tick();
    total++; if (bi.out_valid !== 1'b1 || bi.out_word !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL bp_hold got v=%0b w=%h exp v=1 w=ffffffff", bi.out_valid, bi.out_word); end
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    bi.out_ready = 1'b1;
    tick();
    total++; if (bi.out_valid !== 1'b0 || bi.in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_after_emit got v=%0b rdy=%0b exp 0/1", bi.out_valid, bi.in_ready); end
    drive(1'b1, 16'h1234, 5'd16, 1'b0); tick();
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    total++; if (bi.out_valid !== 1'b1 || bi.out_word !== 32'hFFFF1234) begin
      bad++; $display("FAIL bp_next_word got v=%0b w=%h exp v=1 w=ffff1234", bi.out_valid, bi.out_word); end
    tick();
  endtask

  task automatic test_zero_overrange();
    bi.out_ready = 1'b1;
    drive(1'b1, 16'hFFFF, 5'd0, 1'b0);  tick();
    drive(1'b1, 16'hA5A5, 5'd20, 1'b0); tick();
    drive(1'b1, 16'h5A5A, 5'd16, 1'b0); tick();
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    total++; if (bi.out_valid !== 1'b1 || bi.out_word !== 32'hA5A55A5A) begin
      bad++; $display("FAIL zo_word got v=%0b w=%h exp v=1 w=a5a55a5a", bi.out_valid, bi.out_word); end
    tick();
    drive(1'b0, 16'h0, 5'd0, 1'b1); tick();
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    for (int k = 0; k < 8 && !bi.out_last; k++) tick();
    total++; if (bi.out_valid !== 1'b1 || bi.out_last !== 1'b1 || bi.out_word !== 32'h0 || bi.out_bits_valid !== 6'd0) begin
      bad++; $display("FAIL zo_empty_last got v=%0b last=%0b w=%h bv=%0d exp 1/1/0/0",
                      bi.out_valid, bi.out_last, bi.out_word, bi.out_bits_valid); end
    tick();
    total++; if (bi.flush_done !== 1'b1) begin bad++; $display("FAIL zo_done got=%0b exp=1", bi.flush_done); end
    tick();
  endtask

  task automatic test_flush_accept();
    bi.out_ready = 1'b1;
    drive(1'b1, 16'hFFFF, 5'd16, 1'b0); tick();
    drive(1'b1, 16'hFFFF, 5'd15, 1'b0); tick();
    total++; if (bi.out_valid !== 1'b0) begin bad++; $display("FAIL fa_fill31 got v=%0b exp=0", bi.out_valid); end
    drive(1'b1, 16'h8000, 5'd1, 1'b1); tick();
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    total++; if (bi.out_valid !== 1'b1 || bi.out_word !== 32'hFFFFFFFF || bi.out_last !== 1'b0) begin
      bad++; $display("FAIL fa_word got v=%0b w=%h last=%0b exp 1/ffffffff/0", bi.out_valid, bi.out_word, bi.out_last); end
    tick();
    for (int k = 0; k < 8 && !bi.out_last; k++) tick();
    total++; if (bi.out_last !== 1'b1 || bi.out_word !== 32'h0 || bi.out_bits_valid !== 6'd0) begin
      bad++; $display("FAIL fa_last got last=%0b w=%h bv=%0d exp 1/0/0", bi.out_last, bi.out_word, bi.out_bits_valid); end
    tick();
    total++; if (bi.flush_done !== 1'b1) begin bad++; $display("FAIL fa_done got=%0b exp=1", bi.flush_done); end
    tick();
  endtask

  task automatic test_reset_mid();
    bi.out_ready = 1'b1;
    drive(1'b1, 16'hFFFF, 5'd16, 1'b0); tick();
    drive(1'b1, 16'hF000, 5'd4, 1'b0);  tick();
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++; if (bi.out_valid !== 1'b0 || bi.out_word !== 32'h0) begin
      bad++; $display("FAIL rm_in_reset got v=%0b w=%h exp 0/0", bi.out_valid, bi.out_word); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (bi.in_ready !== 1'b1 || bi.out_valid !== 1'b0) begin
      bad++; $display("FAIL rm_release got rdy=%0b v=%0b exp 1/0", bi.in_ready, bi.out_valid); end
    drive(1'b1, 16'h1357, 5'd16, 1'b0); tick();
    total++; if (bi.out_valid !== 1'b0) begin bad++; $display("FAIL rm_partial got v=%0b exp=0", bi.out_valid); end
    drive(1'b1, 16'h9BDF, 5'd16, 1'b0); tick();
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    total++; if (bi.out_valid !== 1'b1 || bi.out_word !== 32'h13579BDF) begin
      bad++; $display("FAIL rm_word got v=%0b w=%h exp v=1 w=13579bdf", bi.out_valid, bi.out_word); end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_groups();
    test_short_flush();
    test_backpressure();
    test_zero_overrange();
    test_flush_accept();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/out_bits_packer.md
Name: out_bits_packer

Overview:
- Sits directly downstream of the arithmetic encoder's out_bits stage.
- Each cycle it takes the variable-length group of settled MSBs (0-16 bits, MSB-aligned) and appends it to a bit accumulator.
- It emits fixed-width packed words on a valid/ready stream to the output FIFO/DMA.
- A flush request drains all buffered bits and closes the stream with a zero-padded final word marked last.

Parameters:
- IN_WIDTH, 16: width of the incoming bit group. Equals the encoder bound width.
- OUT_WIDTH, 32: packed output word width. Must be a multiple of 8 and at least IN_WIDTH.
- CNT_WIDTH, 5: width of in_count. Must satisfy 2^CNT_WIDTH > IN_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  group present.
- in_ready  out  1  packer can accept a group this cycle.
- in_bits  in  IN_WIDTH  group bits, MSB-aligned; bits below the count are don't-care.
- in_count  in  CNT_WIDTH  number of valid bits, 0..IN_WIDTH.
- flush_req  in  1  single-cycle request to end the stream.
- out_valid  out  1  packed word available.
- out_ready  in  1  sink accepts the word.
- out_word  out  OUT_WIDTH  packed bits; first-received bit at MSB.
- out_bits_valid  out  $clog2(OUT_WIDTH)+1  valid bits in out_word. Equals OUT_WIDTH except on the last word.
- out_last  out  1  final word of the stream.
- flush_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: accumulator 0, fill 0, state RUN, out_valid 0, out_last 0, out_bits_valid 0, flush_done 0, out_word 0. in_ready is 1 immediately after reset deassertion.
- Accumulator: a register buf of OUT_WIDTH+IN_WIDTH bits, left-justified, plus a fill counter with range 0..OUT_WIDTH+IN_WIDTH.
- Accepting a group (in_valid && in_ready):
  - Bits below in_count are masked to 0.
  - The group is ORed into buf starting at position fill from the MSB.
  - fill increases by in_count.
  - in_count > IN_WIDTH is clamped to IN_WIDTH.
  - in_count = 0 is accepted and has no effect.
- in_ready = (state==RUN) && (fill <= OUT_WIDTH). This is registered-state only, with no combinational path from out_ready.
- out_word is always buf[top OUT_WIDTH bits].
- out_valid = (fill >= OUT_WIDTH) in RUN or DRAIN; it is 1 in LAST.
- Emit (out_valid && out_ready): buf shifts left by OUT_WIDTH and fill decreases by OUT_WIDTH.
- Simultaneous accept and emit in the same cycle: the shift applies first, then the insert at fill-OUT_WIDTH. No bit is lost or duplicated.
- Output stability: while out_valid=1 and out_ready=0, out_word, out_last and out_bits_valid hold stable.
- State machine:
  - RUN: normal operation. flush_req goes to DRAIN. An input accepted in the same cycle as flush_req is included.
  - DRAIN: in_ready=0; full words continue to emit. When fill < OUT_WIDTH, go to LAST.
  - LAST: out_valid=1, out_last=1, out_bits_valid=fill. out_word holds the residual bits, zero-padded. If fill=0, an empty last word is still emitted (value 0, out_bits_valid=0). On acceptance: buf and fill clear, flush_done pulses for 1 cycle, return to RUN.
- flush_req in DRAIN or LAST is ignored.
- Latency: a group completing a word makes out_valid high on the next cycle.
- Throughput: one group per cycle sustained, provided out_ready=1.
- Reset mid-operation: all buffered bits are discarded and no partial word is emitted. in_ready is valid on the first cycle after deassertion.

Optional Feature:
- Macro: PACKER_STATS_EN.
- Defined: adds output port total_bits [31:0], a count of all bits accepted since reset or the last flush_done. It saturates at 0xFFFFFFFF, clears on rst and on the flush_done cycle, and updates the cycle after acceptance.
- Undefined: the port and counter are absent. Core behaviour is identical.

Test Plan:
- Full groups: 2 groups of 0xABCD, count 16, with out_ready=1 → one word 0xABCDABCD, out_last=0; fill returns to 0.
- Short groups and flush: 0xB000 count 5, then 0x6000 count 3, then flush_req → single word 0xB3000000, out_bits_valid=8, out_last=1; flush_done pulses the cycle after acceptance.
- Backpressure: out_ready=0, feed 0xFFFF count 16 three times → in_ready drops after the third (fill=48). out_word=0xFFFFFFFF held stable. Raising out_ready emits it, then a word becomes pending only after another 16 bits.
- Zero/overrange counts: in_count=0 with in_bits=0xFFFF → fill unchanged. in_count=20 → treated as 16. Flush with fill=0 → last word 0x00000000, out_bits_valid=0.
- Simultaneous flush and accept: flush_req in the same cycle as 0x8000 count 1, with fill=31 (all 1s) → word 0xFFFFFFFF, then last word 0x00000000, out_bits_valid=0.
- Reset mid-stream: assert rst with fill=20 and out_valid=0 → after release, out_valid=0 and fill=0; the next 32 bits fed form the first word intact.
